// File: rtl/mlp_pkg.sv
// Shared types and sizing for the axi_mlp stream sequencer and its argmax tracker.
package mlp_pkg;

  localparam int IMG_LEN = 784;
  localparam int HID_LEN = 30;
  localparam int OUT_LEN = 10;
  localparam int IMG_AW  = 10;
  localparam int HID_AW  = 5;
  localparam int CL_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_IMG = 3'd1,
    S_L1_W     = 3'd2,
    S_L1_B     = 3'd3,
    S_L1_WAIT  = 3'd4,
    S_L2_W     = 3'd5,
    S_L2_B     = 3'd6,
    S_L2_WAIT  = 3'd7
  } seq_state_t;

endpackage

// File: rtl/mlp_argmax.sv
// Running signed argmax over output-layer activations; strict compare keeps the lower index on ties.
module mlp_argmax
  import mlp_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic                    clk_s,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    valid,
  input  logic signed [WIDTH-1:0] value,
  input  logic [CL_W-1:0]         index,
  output logic [CL_W-1:0]         best_idx
);

  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] best_val;
  logic [CL_W-1:0]         best_idx_q;
  logic                    take;

  // best_idx already reflects the value presented this cycle, so the final
  // neuron's result can be latched in the same edge it arrives.
  always_comb begin
    take     = valid && (value > best_val);
    best_idx = take ? index : best_idx_q;
  end

  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      best_val   <= MOST_NEG;
      best_idx_q <= '0;
    end else if (clear) begin
      best_val   <= MOST_NEG;
      best_idx_q <= '0;
    end else if (take) begin
      best_val   <= value;
      best_idx_q <= index;
    end
  end

endmodule

// File: rtl/mlp_stream_sequencer.sv
// Stream sequencer for the axi_mlp core: steers image/weight/bias words and tracks the winning class.
// Optional MLP_SEQ_TLAST_CHECK_EN adds TLAST framing checks with a sticky err_o.
//
// state      | meaning
// S_IDLE     | ready, waiting for a start rising edge
// S_LOAD_IMG | writing image words into the image buffer
// S_L1_W     | hidden neuron weights, operands from image buffer
// S_L1_B     | hidden neuron bias word
// S_L1_WAIT  | waiting for activated hidden result, stream stalled
// S_L2_W     | output neuron weights, operands from hidden buffer
// S_L2_B     | output neuron bias word
// S_L2_WAIT  | waiting for output activation, argmax update
module mlp_stream_sequencer
  import mlp_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic                    s00_axis_aclk,
  input  logic                    s00_axis_aresetn,
  input  logic                    start_i,
  output logic                    ready_o,
  output logic [CL_W-1:0]         cl_num_o,
`ifdef MLP_SEQ_TLAST_CHECK_EN
  input  logic                    s_tlast_i,
  output logic                    err_o,
`endif
  input  logic [WIDTH-1:0]        s_tdata_i,
  input  logic                    s_tvalid_i,
  output logic                    s_tready_o,
  output logic                    img_we_o,
  output logic [IMG_AW-1:0]       img_addr_o,
  output logic [WIDTH-1:0]        img_wdata_o,
  output logic [IMG_AW-1:0]       op_raddr_o,
  output logic                    op_sel_o,
  output logic [WIDTH-1:0]        w_data_o,
  output logic                    mac_clr_o,
  output logic                    mac_en_o,
  output logic                    bias_en_o,
  output logic                    hid_we_o,
  output logic [HID_AW-1:0]       hid_addr_o,
  input  logic                    act_valid_i,
  input  logic signed [WIDTH-1:0] act_i
);

  localparam logic [IMG_AW-1:0] IMG_LAST  = IMG_AW'(IMG_LEN - 1);
  localparam logic [IMG_AW-1:0] HID_WLAST = IMG_AW'(HID_LEN - 1);
  localparam logic [HID_AW-1:0] HID_NLAST = HID_AW'(HID_LEN - 1);
  localparam logic [HID_AW-1:0] OUT_NLAST = HID_AW'(OUT_LEN - 1);

  seq_state_t        state;
  logic              start_q;
  logic              start_rise;
  logic              xfer;
  logic [IMG_AW-1:0] word_cnt;
  logic [HID_AW-1:0] neuron_cnt;
  logic [WIDTH-1:0]  w_s1;
  logic              en_s1;
  logic              bias_s1;
  logic              am_clear;
  logic              am_valid;
  logic [CL_W-1:0]   best_idx;

  assign start_rise = start_i & ~start_q;
  assign xfer       = s_tvalid_i & s_tready_o;
  assign am_clear   = (state == S_IDLE) && start_rise;
  assign am_valid   = (state == S_L2_WAIT) && act_valid_i;

`ifdef MLP_SEQ_TLAST_CHECK_EN
  logic last_expected;
  logic frame_err;
  assign last_expected = ((state == S_LOAD_IMG) && (word_cnt == IMG_LAST)) ||
                         (state == S_L1_B) || (state == S_L2_B);
  assign frame_err     = xfer && (s_tlast_i != last_expected);
`endif

  mlp_argmax #(.WIDTH(WIDTH)) u_argmax (
    .clk_s    (s00_axis_aclk),
    .rst_n    (s00_axis_aresetn),
    .clear    (am_clear),
    .valid    (am_valid),
    .value    (act_i),
    .index    (CL_W'(neuron_cnt)),
    .best_idx (best_idx)
  );

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      ready_o     <= 1'b1;
      cl_num_o    <= '0;
      s_tready_o  <= 1'b0;
      img_we_o    <= 1'b0;
      img_addr_o  <= '0;
      img_wdata_o <= '0;
      op_raddr_o  <= '0;
      op_sel_o    <= 1'b0;
      w_data_o    <= '0;
      mac_clr_o   <= 1'b0;
      mac_en_o    <= 1'b0;
      bias_en_o   <= 1'b0;
      hid_we_o    <= 1'b0;
      hid_addr_o  <= '0;
      word_cnt    <= '0;
      neuron_cnt  <= '0;
      w_s1        <= '0;
      en_s1       <= 1'b0;
      bias_s1     <= 1'b0;
`ifdef MLP_SEQ_TLAST_CHECK_EN
      err_o       <= 1'b0;
`endif
    end else begin
      start_q   <= start_i;
      img_we_o  <= 1'b0;
      mac_clr_o <= 1'b0;
      hid_we_o  <= 1'b0;
      en_s1     <= 1'b0;
      bias_s1   <= 1'b0;
      // Weights wait one extra stage so they meet the operand read data.
      mac_en_o  <= en_s1;
      bias_en_o <= bias_s1;
      w_data_o  <= w_s1;

      case (state)
        S_IDLE: begin
          if (start_rise) begin
            ready_o    <= 1'b0;
            word_cnt   <= '0;
            neuron_cnt <= '0;
            s_tready_o <= 1'b1;
            state      <= S_LOAD_IMG;
`ifdef MLP_SEQ_TLAST_CHECK_EN
            err_o      <= 1'b0;
`endif
          end
        end
        S_LOAD_IMG: begin
          if (xfer) begin
            img_we_o    <= 1'b1;
            img_addr_o  <= word_cnt;
            img_wdata_o <= s_tdata_i;
            if (word_cnt == IMG_LAST) begin
              word_cnt  <= '0;
              mac_clr_o <= 1'b1;
              state     <= S_L1_W;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        S_L1_W, S_L2_W: begin
          if (xfer) begin
            op_raddr_o <= word_cnt;
            op_sel_o   <= (state == S_L2_W);
            w_s1       <= s_tdata_i;
            en_s1      <= 1'b1;
            if (word_cnt == ((state == S_L1_W) ? IMG_LAST : HID_WLAST)) begin
              word_cnt <= '0;
              state    <= (state == S_L1_W) ? S_L1_B : S_L2_B;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        S_L1_B, S_L2_B: begin
          if (xfer) begin
            w_s1       <= s_tdata_i;
            bias_s1    <= 1'b1;
            s_tready_o <= 1'b0;
            state      <= (state == S_L1_B) ? S_L1_WAIT : S_L2_WAIT;
          end
        end
        S_L1_WAIT: begin
          if (act_valid_i) begin
            hid_we_o   <= 1'b1;
            hid_addr_o <= neuron_cnt;
            s_tready_o <= 1'b1;
            mac_clr_o  <= 1'b1;
            if (neuron_cnt == HID_NLAST) begin
              neuron_cnt <= '0;
              state      <= S_L2_W;
            end else begin
              neuron_cnt <= neuron_cnt + 1'b1;
              state      <= S_L1_W;
            end
          end
        end
        S_L2_WAIT: begin
          if (act_valid_i) begin
            if (neuron_cnt == OUT_NLAST) begin
              neuron_cnt <= '0;
              cl_num_o   <= best_idx;
              ready_o    <= 1'b1;
              state      <= S_IDLE;
            end else begin
              neuron_cnt <= neuron_cnt + 1'b1;
              s_tready_o <= 1'b1;
              mac_clr_o  <= 1'b1;
              state      <= S_L2_W;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

`ifdef MLP_SEQ_TLAST_CHECK_EN
      // Misframed word: drop it, flag, and return to idle keeping the last class.
      if (frame_err) begin
        err_o      <= 1'b1;
        state      <= S_IDLE;
        ready_o    <= 1'b1;
        s_tready_o <= 1'b0;
        img_we_o   <= 1'b0;
        mac_clr_o  <= 1'b0;
        en_s1      <= 1'b0;
        bias_s1    <= 1'b0;
        word_cnt   <= '0;
        neuron_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mlp_stream_sequencer.sv
// Directed bench for mlp_stream_sequencer: full classifications, stalls, reset mid-run, optional TLAST check.
module tb_mlp_stream_sequencer;
  import mlp_pkg::*;

  localparam int W = 18;
  localparam logic [W-1:0] BIAS = 18'h15555;
  localparam int MAC_PER_RUN = HID_LEN * IMG_LEN + OUT_LEN * HID_LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                start_i = 1'b0;
  logic                ready_o;
  logic [CL_W-1:0]     cl_num_o;
  logic [W-1:0]        s_tdata = '0;
  logic                s_tvalid = 1'b0;
  logic                s_tready_o;
  logic                img_we_o;
  logic [IMG_AW-1:0]   img_addr_o;
  logic [W-1:0]        img_wdata_o;
  logic [IMG_AW-1:0]   op_raddr_o;
  logic                op_sel_o;
  logic [W-1:0]        w_data_o;
  logic                mac_clr_o, mac_en_o, bias_en_o, hid_we_o;
  logic [HID_AW-1:0]   hid_addr_o;
  logic                act_valid = 1'b0;
  logic signed [W-1:0] act = '0;
`ifdef MLP_SEQ_TLAST_CHECK_EN
  logic                s_tlast = 1'b0;
  logic                err_o;
`endif

  mlp_stream_sequencer #(.WIDTH(W)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .start_i          (start_i),
    .ready_o          (ready_o),
    .cl_num_o         (cl_num_o),
`ifdef MLP_SEQ_TLAST_CHECK_EN
    .s_tlast_i        (s_tlast),
    .err_o            (err_o),
`endif
    .s_tdata_i        (s_tdata),
    .s_tvalid_i       (s_tvalid),
    .s_tready_o       (s_tready_o),
    .img_we_o         (img_we_o),
    .img_addr_o       (img_addr_o),
    .img_wdata_o      (img_wdata_o),
    .op_raddr_o       (op_raddr_o),
    .op_sel_o         (op_sel_o),
    .w_data_o         (w_data_o),
    .mac_clr_o        (mac_clr_o),
    .mac_en_o         (mac_en_o),
    .bias_en_o        (bias_en_o),
    .hid_we_o         (hid_we_o),
    .hid_addr_o       (hid_addr_o),
    .act_valid_i      (act_valid),
    .act_i            (act)
  );

  int errors = 0;
  int checks = 0;
  int tready_bad = 0;
  int l2_acts [OUT_LEN];
  logic cur_sel = 1'b0;

  function automatic logic [W-1:0] img_val(input int i);
    return W'(i * 3 + 1);
  endfunction

  function automatic logic [W-1:0] w_val(input int k);
    return W'(k * 5 + 7);
  endfunction

  // Output monitor: counts strobes and flags address/data misalignment.
  int img_cnt = 0, img_bad = 0, img_last = -1;
  int hid_cnt = 0, hid_bad = 0, hid_last = -1;
  int mac_cnt = 0, bias_cnt = 0, clr_cnt = 0, mac_bad = 0;
  int raddr_prev = 0;
  logic mac_en_prev = 1'b0;

  always @(negedge clk) begin
    if (img_we_o) begin
      if (!(img_addr_o == '0 || int'(img_addr_o) == img_last + 1) ||
          img_wdata_o !== img_val(int'(img_addr_o)))
        img_bad++;
      img_last = int'(img_addr_o);
      img_cnt++;
    end
    if (hid_we_o) begin
      if (!(hid_addr_o == '0 || int'(hid_addr_o) == hid_last + 1)) hid_bad++;
      hid_last = int'(hid_addr_o);
      hid_cnt++;
    end
    if (mac_en_o) begin
      mac_cnt++;
      if (w_data_o !== w_val(raddr_prev) || op_sel_o !== cur_sel) mac_bad++;
    end
    if (bias_en_o) begin
      bias_cnt++;
      if (w_data_o !== BIAS || mac_en_o || !mac_en_prev) mac_bad++;
    end
    if (mac_clr_o) clr_cnt++;
    raddr_prev  = int'(op_raddr_o);
    mac_en_prev = mac_en_o;
  end

  task automatic bail();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic last);
    s_tdata  = d;
    s_tvalid = 1'b1;
`ifdef MLP_SEQ_TLAST_CHECK_EN
    s_tlast  = last;
`else
    if (last) s_tdata = d;
`endif
    for (int n = 0; ; n++) begin
      if (s_tready_o) break;
      if (n == 2000) begin
        checks++; errors++;
        $display("FAIL stream_stall: s_tready_o=0 after %0d cycles, required 1", n);
        bail();
      end
      @(negedge clk);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_act(input int delay, input int val);
    for (int d = 0; d < delay; d++) begin
      if (s_tready_o !== 1'b0) tready_bad++;
      @(negedge clk);
    end
    act_valid = 1'b1;
    act       = W'(val);
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  task automatic run_image(input bit toggle, input int l1_delay, input int stop_at,
                           input bit disturb, output logic ready_before_last);
    int words;
    words = 0;
    cur_sel = 1'b0;
    ready_before_last = 1'bx;
    for (int i = 0; i < IMG_LEN; i++) begin
      if (toggle) begin s_tvalid = 1'b0; @(negedge clk); end
      send_word(img_val(i), i == IMG_LEN - 1);
      words++;
    end
    for (int n = 0; n < HID_LEN; n++) begin
      if (disturb && n == 5) begin
        act_valid = 1'b1; act = 18'sd77; start_i = 1'b1;
        @(negedge clk);
        act_valid = 1'b0; start_i = 1'b0;
      end
      for (int k = 0; k < IMG_LEN; k++) begin
        send_word(w_val(k), 1'b0);
        words++;
        if (words == stop_at) return;
      end
      send_word(BIAS, 1'b1);
      wait_act(l1_delay, n * 11 - 40);
    end
    cur_sel = 1'b1;
    for (int n = 0; n < OUT_LEN; n++) begin
      for (int k = 0; k < HID_LEN; k++) send_word(w_val(k), 1'b0);
      send_word(BIAS, 1'b1);
      if (n == OUT_LEN - 1) ready_before_last = ready_o;
      wait_act(3, l2_acts[n]);
    end
  endtask

  task automatic check_run(input string tag, input int cl_exp, input logic rb,
                           input int i0, input int ib0, input int h0, input int hb0,
                           input int m0, input int b0, input int c0, input int mb0, input int tb0);
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL %s ready_before_last: got %b, required 0", tag, rb); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL %s ready_done: got %b, required 1", tag, ready_o); end
    checks++; if (cl_num_o !== CL_W'(cl_exp)) begin errors++; $display("FAIL %s cl_num: got %0d, required %0d", tag, cl_num_o, cl_exp); end
    checks++; if (img_cnt - i0 != IMG_LEN) begin errors++; $display("FAIL %s img_we_count: got %0d, required %0d", tag, img_cnt - i0, IMG_LEN); end
    checks++; if (img_bad - ib0 != 0 || img_last != IMG_LEN - 1) begin errors++; $display("FAIL %s img_addr_data: bad=%0d last=%0d, required bad=0 last=%0d", tag, img_bad - ib0, img_last, IMG_LEN - 1); end
    checks++; if (hid_cnt - h0 != HID_LEN || hid_bad - hb0 != 0 || hid_last != HID_LEN - 1) begin errors++; $display("FAIL %s hid_we: cnt=%0d bad=%0d last=%0d, required %0d/0/%0d", tag, hid_cnt - h0, hid_bad - hb0, hid_last, HID_LEN, HID_LEN - 1); end
    checks++; if (mac_cnt - m0 != MAC_PER_RUN) begin errors++; $display("FAIL %s mac_en_count: got %0d, required %0d", tag, mac_cnt - m0, MAC_PER_RUN); end
    checks++; if (bias_cnt - b0 != HID_LEN + OUT_LEN) begin errors++; $display("FAIL %s bias_en_count: got %0d, required %0d", tag, bias_cnt - b0, HID_LEN + OUT_LEN); end
    checks++; if (clr_cnt - c0 != HID_LEN + OUT_LEN) begin errors++; $display("FAIL %s mac_clr_count: got %0d, required %0d", tag, clr_cnt - c0, HID_LEN + OUT_LEN); end
    checks++; if (mac_bad - mb0 != 0) begin errors++; $display("FAIL %s weight_align: got %0d bad, required 0", tag, mac_bad - mb0); end
    checks++; if (tready_bad - tb0 != 0) begin errors++; $display("FAIL %s tready_in_wait: got %0d high cycles, required 0", tag, tready_bad - tb0); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready_o !== 1'b1 || cl_num_o !== '0 || s_tready_o !== 1'b0) begin errors++;
      $display("FAIL reset_outputs: ready=%b cl=%0d tready=%b, required 1/0/0", ready_o, cl_num_o, s_tready_o); end
    checks++; if ({img_we_o, mac_clr_o, mac_en_o, bias_en_o, hid_we_o} !== 5'b0) begin errors++;
      $display("FAIL reset_strobes: got %b, required 00000", {img_we_o, mac_clr_o, mac_en_o, bias_en_o, hid_we_o}); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (ready_o !== 1'b1 || s_tready_o !== 1'b0) begin errors++;
      $display("FAIL idle_hold: ready=%b tready=%b, required 1/0", ready_o, s_tready_o); end
  endtask

  task automatic test_start_level_full_run();
    int i0, ib0, h0, hb0, m0, b0, c0, mb0, tb0, hi;
    logic rb;
    i0 = img_cnt; ib0 = img_bad; h0 = hid_cnt; hb0 = hid_bad;
    m0 = mac_cnt; b0 = bias_cnt; c0 = clr_cnt; mb0 = mac_bad; tb0 = tready_bad;
    l2_acts = '{5, 9, -3, 9, 2, 1, 0, -7, 4, 0};
    start_i = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (ready_o !== 1'b0 || s_tready_o !== 1'b1) begin errors++;
      $display("FAIL start_launch: ready=%b tready=%b, required 0/1", ready_o, s_tready_o); end
    run_image(1'b1, 20, -1, 1'b0, rb);
    check_run("run_a", 1, rb, i0, ib0, h0, hb0, m0, b0, c0, mb0, tb0);
    hi = 0;
    for (int n = 0; n < 20; n++) begin
      if (s_tready_o !== 1'b0 || ready_o !== 1'b1) hi++;
      @(negedge clk);
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL start_level_rerun: %0d busy cycles, required 0", hi); end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic rb;
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    run_image(1'b0, 3, IMG_LEN + 12 * (IMG_LEN + 1) + 100, 1'b0, rb);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1 || cl_num_o !== '0 || s_tready_o !== 1'b0) begin errors++;
      $display("FAIL reset_mid: ready=%b cl=%0d tready=%b, required 1/0/0", ready_o, cl_num_o, s_tready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back_fresh_run();
    int i0, ib0, h0, hb0, m0, b0, c0, mb0, tb0;
    logic rb;
    i0 = img_cnt; ib0 = img_bad; h0 = hid_cnt; hb0 = hid_bad;
    m0 = mac_cnt; b0 = bias_cnt; c0 = clr_cnt; mb0 = mac_bad; tb0 = tready_bad;
    l2_acts = '{-5, -2, -9, -1, -8, -3, -20, 7, 7, -100};
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    run_image(1'b0, 3, -1, 1'b1, rb);
    check_run("run_c", 7, rb, i0, ib0, h0, hb0, m0, b0, c0, mb0, tb0);
  endtask

`ifdef MLP_SEQ_TLAST_CHECK_EN
  task automatic test_tlast();
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    for (int i = 0; i <= 500; i++) send_word(img_val(i), i == 500);
    checks++; if (err_o !== 1'b1 || ready_o !== 1'b1 || s_tready_o !== 1'b0 || cl_num_o !== 4'd7) begin errors++;
      $display("FAIL tlast_abort: err=%b ready=%b tready=%b cl=%0d, required 1/1/0/7", err_o, ready_o, s_tready_o, cl_num_o); end
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tlast_clear: err=%b, required 0", err_o); end
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_start_level_full_run();
    test_reset_mid_run();
    test_back_to_back_fresh_run();
`ifdef MLP_SEQ_TLAST_CHECK_EN
    test_tlast();
`endif
    bail();
  end

endmodule
